// File: rtl/anim_frame_scheduler_if.sv
// anim_frame_scheduler_if: game-FSM side bundle for the LED frame scheduler (status, animation queue, frame outputs).
interface anim_frame_scheduler_if #(
    parameter int HOLD_W = 8
);
    logic              stat_we;
    logic [63:0]       stat_a;
    logic [63:0]       stat_b;
    logic              anim_valid;
    logic              anim_ready;
    logic [63:0]       anim_a;
    logic [63:0]       anim_b;
    logic [HOLD_W-1:0] anim_hold;
    logic              flush;
    logic [63:0]       frame_a;
    logic [63:0]       frame_b;
    logic              playing;
    logic              anim_done;
    logic [1:0]        queue_cnt;

    modport master (
        output stat_we, stat_a, stat_b, anim_valid, anim_a, anim_b, anim_hold, flush,
        input  anim_ready, frame_a, frame_b, playing, anim_done, queue_cnt
    );
    modport slave (
        input  stat_we, stat_a, stat_b, anim_valid, anim_a, anim_b, anim_hold, flush,
        output anim_ready, frame_a, frame_b, playing, anim_done, queue_cnt
    );
endinterface

// File: rtl/anim_frame_scheduler.sv
// anim_frame_scheduler: plays queued timed animation frame pairs on two LED panels, else shows status frames.
module anim_frame_scheduler #(
    parameter int TICK_DIV = 50000,
    parameter int HOLD_W   = 8
) (
    input logic                   clk,
    input logic                   reset,
    anim_frame_scheduler_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, PLAY} state_t;
    typedef struct packed {
        logic [63:0]       a;
        logic [63:0]       b;
        logic [HOLD_W-1:0] hold;
    } ent_t;

    state_t            state_q, state_d;
    ent_t              mem_q [2];
    ent_t              in_ent, head;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [HOLD_W-1:0] rem_q, rem_d;
    logic [63:0]       stat_a_q, stat_a_d, stat_b_q, stat_b_d;
    logic [63:0]       frame_a_q, frame_a_d, frame_b_q, frame_b_d;
    logic              playing_q, playing_d, done_q, done_d;
    logic              push, pop, tick, last;

    assign bus.anim_ready = cnt_q != 2'd2 && !bus.flush;
    assign bus.frame_a    = frame_a_q;
    assign bus.frame_b    = frame_b_q;
    assign bus.playing    = playing_q;
    assign bus.anim_done  = done_q;
    assign bus.queue_cnt  = cnt_q;

    always_comb begin
        push   = bus.anim_valid && bus.anim_ready;
        in_ent = '{a: bus.anim_a, b: bus.anim_b,
                   hold: bus.anim_hold == '0 ? HOLD_W'(1) : bus.anim_hold};
        tick   = state_q == PLAY && pre_q == PRE_MAX;
        last   = tick && rem_q == HOLD_W'(1);
        // an entry pushed on the completing edge may be popped straight through
        pop    = !bus.flush && ((state_q == IDLE && cnt_q != 2'd0) ||
                                (last && (cnt_q != 2'd0 || push)));
        head   = cnt_q != 2'd0 ? mem_q[rd_q] : in_ent;
    end

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        rem_d     = rem_q;
        frame_a_d = frame_a_q;
        frame_b_d = frame_b_q;
        rd_d      = rd_q ^ pop;
        wr_d      = wr_q ^ push;
        cnt_d     = cnt_q + 2'(push) - 2'(pop);
        stat_a_d  = bus.stat_we ? bus.stat_a : stat_a_q;
        stat_b_d  = bus.stat_we ? bus.stat_b : stat_b_q;
        done_d    = last && !bus.flush;
        if (bus.flush) begin
            state_d   = IDLE;
            cnt_d     = 2'd0;
            rd_d      = 1'b0;
            wr_d      = 1'b0;
            pre_d     = '0;
            rem_d     = '0;
            frame_a_d = stat_a_d;
            frame_b_d = stat_b_d;
        end else if (pop) begin
            state_d   = PLAY;
            pre_d     = '0;
            rem_d     = head.hold;
            frame_a_d = head.a;
            frame_b_d = head.b;
        end else if (last || state_q == IDLE) begin
            state_d   = IDLE;
            pre_d     = '0;
            rem_d     = '0;
            frame_a_d = stat_a_q;
            frame_b_d = stat_b_q;
        end else begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            rem_d = tick && rem_q != '0 ? rem_q - HOLD_W'(1) : rem_q;
        end
        playing_d = state_d == PLAY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_q     <= '{default: '0};
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= 2'd0;
            pre_q     <= '0;
            rem_q     <= '0;
            stat_a_q  <= '0;
            stat_b_q  <= '0;
            frame_a_q <= '0;
            frame_b_q <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= in_ent;
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            rem_q     <= rem_d;
            stat_a_q  <= stat_a_d;
            stat_b_q  <= stat_b_d;
            frame_a_q <= frame_a_d;
            frame_b_q <= frame_b_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_anim_frame_scheduler.sv
// tb_anim_frame_scheduler: scoreboard bench; a queue/cycle-budget model predicts every post-edge output.
module tb_anim_frame_scheduler;
    localparam int TD = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        int          hold;
    } ent_t;

    typedef struct {
        logic [63:0] fa;
        logic [63:0] fb;
        logic        play;
        logic        done;
        int          cnt;
        logic        ready;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    anim_frame_scheduler_if #(.HOLD_W(8)) bus ();
    anim_frame_scheduler #(.TICK_DIV(TD), .HOLD_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    ent_t        mq[$];
    exp_t        exp_q[$];
    exp_t        e;
    bit          m_play, m_done;
    int          m_left;
    logic [63:0] m_sa, m_sb, m_fa, m_fb;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_a", bus.frame_a, e.fa);
            chk("frame_b", bus.frame_b, e.fb);
            chk("playing", 64'(bus.playing), 64'(e.play));
            chk("anim_done", 64'(bus.anim_done), 64'(e.done));
            chk("queue_cnt", 64'(bus.queue_cnt), 64'(e.cnt));
            chk("anim_ready", 64'(bus.anim_ready), 64'(e.ready));
        end
    end

    // Model one clock edge from the inputs currently applied, queue the expectation, advance.
    task automatic step();
        int   old;
        bit   psh, fin;
        ent_t en;
        if (reset) begin
            mq.delete();
            m_play = 0; m_done = 0; m_left = 0;
            m_sa = '0; m_sb = '0; m_fa = '0; m_fb = '0;
        end else begin
            old = mq.size();
            psh = bus.anim_valid && old != 2 && !bus.flush;
            fin = m_play && m_left == 1;
            m_done = 0;
            if (bus.flush) begin
                mq.delete();
                m_play = 0;
                m_left = 0;
                m_fa = bus.stat_we ? bus.stat_a : m_sa;
                m_fb = bus.stat_we ? bus.stat_b : m_sb;
            end else begin
                if (psh) mq.push_back('{bus.anim_a, bus.anim_b,
                                        bus.anim_hold == 0 ? 1 : int'(bus.anim_hold)});
                if ((!m_play && old > 0) || (fin && mq.size() > 0)) begin
                    en = mq.pop_front();
                    m_fa = en.a; m_fb = en.b;
                    m_left = en.hold * TD;
                    m_play = 1;
                    m_done = fin;
                end else if (fin) begin
                    m_play = 0; m_done = 1;
                    m_fa = m_sa; m_fb = m_sb;
                end else if (m_play) begin
                    m_left--;
                end else begin
                    m_fa = m_sa; m_fb = m_sb;
                end
            end
            if (bus.stat_we) begin
                m_sa = bus.stat_a;
                m_sb = bus.stat_b;
            end
        end
        exp_q.push_back('{m_fa, m_fb, m_play, m_done, mq.size(), mq.size() != 2 && !bus.flush});
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bus.anim_valid = 0; bus.stat_we = 0; bus.flush = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(logic [63:0] a, logic [63:0] b, logic [7:0] h);
        bus.anim_valid = 1; bus.anim_a = a; bus.anim_b = b; bus.anim_hold = h;
        step();
        bus.anim_valid = 0;
    endtask

    task automatic stat(logic [63:0] a, logic [63:0] b);
        bus.stat_we = 1; bus.stat_a = a; bus.stat_b = b;
        step();
        bus.stat_we = 0;
    endtask

    initial begin
        bus.stat_we = 0; bus.stat_a = '0; bus.stat_b = '0;
        bus.anim_valid = 0; bus.anim_a = '0; bus.anim_b = '0; bus.anim_hold = '0;
        bus.flush = 0;
        @(negedge clk);
        reset = 1; step(); step();
        reset = 0;
        stat(64'h7D7D5545_45010101, 64'h0101_89C9_E9FD_FDFD);
        idle(2);
        offer(64'hA1A1_0000_0000_0001, 64'hB1B1_0000_0000_0001, 8'd3);
        idle(16);
        offer(64'h1111, 64'h2222, 8'd1);
        offer(64'h3333, 64'h4444, 8'd2);
        offer(64'h5555, 64'h6666, 8'd1);
        bus.anim_valid = 1; bus.anim_a = 64'h7777; bus.anim_b = 64'h8888; bus.anim_hold = 8'd1;
        step(); step(); step();
        idle(30);
        offer(64'hDEAD, 64'hBEEF, 8'd0);
        idle(8);
        offer(64'hF1, 64'hF2, 8'd5);
        offer(64'hF3, 64'hF4, 8'd5);
        idle(3);
        bus.flush = 1; bus.anim_valid = 1; bus.anim_a = 64'hF5; bus.anim_b = 64'hF6;
        step();
        idle(4);
        offer(64'hC1, 64'hC2, 8'd2);
        idle(2);
        stat(64'h00FF_00FF_00FF_00FF, 64'hFF00_FF00_FF00_FF00);
        idle(12);
        offer(64'hE1, 64'hE2, 8'd4);
        idle(5);
        reset = 1; step();
        reset = 0;
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 500) == 0;
            bus.flush = ($urandom % 40) == 0;
            bus.stat_we = ($urandom % 8) == 0;
            bus.stat_a = {$urandom, $urandom};
            bus.stat_b = {$urandom, $urandom};
            bus.anim_valid = ($urandom % 5) == 0;
            bus.anim_a = {$urandom, $urandom};
            bus.anim_b = {$urandom, $urandom};
            bus.anim_hold = 8'($urandom_range(0, 3));
            step();
        end
        reset = 0;
        idle(2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/anim_frame_scheduler.md
Name: anim_frame_scheduler

Overview:
- Sequences what the two 8x8 LED matrix drivers (panel A = player, panel B = boss/PC) display.
- Game FSM sets persistent status frames (HP bars) at any time, and queues timed animation frame pairs (attack animations) through a valid/ready port into a 2-entry FIFO.
- The block plays queued animations back-to-back, each for a programmed number of ticks, then reverts to the status frames.
- Replaces hand-rolled delay counters in the game FSM with one shared, arbitrated display path.

Parameters:
TICK_DIV, 50000, clk cycles per animation tick (use 4 in simulation)
HOLD_W, 8, width of per-animation hold count in ticks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stat_we  in  1  write status frames this cycle
stat_a  in  64  status frame for panel A
stat_b  in  64  status frame for panel B
anim_valid  in  1  animation request valid
anim_ready  out  1  FIFO can accept (combinational)
anim_a  in  64  animation frame, panel A
anim_b  in  64  animation frame, panel B
anim_hold  in  HOLD_W  display duration in ticks
flush  in  1  drop queued and active animations
frame_a  out  64  registered frame to panel A driver
frame_b  out  64  registered frame to panel B driver
playing  out  1  high while an animation is displayed
anim_done  out  1  one-cycle pulse when an animation completes normally
queue_cnt  out  2  FIFO occupancy (0..2)

Behaviour:
- Reset clears everything to zero: frame_a, frame_b, status registers, FIFO (queue_cnt=0), active entry, prescaler, remaining-tick counter, playing=0, anim_done=0. FSM goes to IDLE. Reset overrides all other inputs in the same cycle.
- anim_ready = (queue_cnt != 2) && !flush, derived from registered count only.
- A push is accepted on an edge where anim_valid && anim_ready. It stores {anim_a, anim_b, anim_hold}.
- Stored anim_hold = 0 is treated as 1.
- Status regs load on any edge with stat_we=1, regardless of FSM state.
- In IDLE, frame_a/frame_b follow the status regs with 1 cycle latency.
- A status write during PLAY is not visible until the return to IDLE.
- FSM states:
  - IDLE: outputs status frames, playing=0. If queue_cnt>0 at an edge: pop head into active, set remaining = hold, clear prescaler, set frame_a/b = active frames, playing=1, go to PLAY.
  - A push at edge k from an empty FIFO is therefore displayed after edge k+1.
  - PLAY: prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs on the edge where prescaler == TICK_DIV-1. Each tick decrements remaining.
  - On the tick where remaining == 1:
    - anim_done=1 for the following cycle.
    - If the FIFO is non-empty (sampled that edge, including an entry pushed on that same edge), pop the next entry and stay in PLAY with prescaler cleared. There is no status frame in between.
    - Otherwise go to IDLE, and frames show the current status regs after that edge.
  - Each animation is therefore shown for exactly hold*TICK_DIV cycles.
- Simultaneous push and pop: occupancy is unchanged and ordering is preserved (FIFO order, oldest first).
- A push while full is refused, because anim_ready=0.
- flush=1 at an edge:
  - FIFO is emptied and the active animation aborted.
  - Go to IDLE, playing=0, frames take the status regs (including a stat_we in the same cycle).
  - No anim_done.
  - anim_valid is ignored that cycle.
  - flush takes priority over tick completion.
- Prescaler and remaining counters never wrap past zero. Remaining-tick width = HOLD_W.

Test Plan:
- Reset then stat_we with stat_a=64'h7D7D5545_45010101, stat_b=64'h0101_89C9_E9FD_FDFD → both frames equal those values 1 cycle later; playing=0, queue_cnt=0, anim_ready=1.
- TICK_DIV=4, push one animation with hold=3 → frames show it from the cycle after acceptance+1 for exactly 12 cycles. anim_done pulses once, then frames revert to the status values; playing falls together with the revert.
- Push three animations back-to-back (holds 1, 2, 1) → first accepted, second and third accepted (queue_cnt peaks at 2 while anim_ready=0 stalls if a fourth is offered). Playback lasts 4, 8 and 4 cycles with no status frame between them; anim_done pulses 3 times.
- hold=0 → displayed for 4 cycles (treated as 1 tick).
- During PLAY with one entry queued, assert flush for 1 cycle alongside a valid push → queue_cnt=0, push dropped, playing=0, status frames shown next cycle, no anim_done.
- stat_we during PLAY with new HP frame → frames unchanged until completion, then show the new status frame; assert reset mid-PLAY → all outputs zero next cycle.
